seven_seg_scanner: RTL

//  Downstream consumer of the 16-bit data-memory test value: registers it and

---
 rtl/seven_seg_scanner.sv | 107 ++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed hex seven-segment driver with a registered value shadow and change pulse.
// Optional LEADING_ZERO_BLANK_EN macro blanks digits above the most significant non-zero nibble.
module seven_seg_scanner #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] test_value,
    input  logic        freeze,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        value_changed
);

    localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic            POL     = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      shadow_q, shadow_d;
    logic             changed_q, changed_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic             blank;

    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        shadow_d  = freeze ? shadow_q : test_value;
        changed_d = !freeze && (test_value != shadow_q);
    end

    // Segment patterns are built active-high {g,f,e,d,c,b,a}; polarity applied last.
    always_comb begin
        nibble = shadow_q[{idx_q, 2'b00} +: 4];
        case (nibble)
            4'h0:    glyph = 7'b0111111;
            4'h1:    glyph = 7'b0000110;
            4'h2:    glyph = 7'b1011011;
            4'h3:    glyph = 7'b1001111;
            4'h4:    glyph = 7'b1100110;
            4'h5:    glyph = 7'b1101101;
            4'h6:    glyph = 7'b1111101;
            4'h7:    glyph = 7'b0000111;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1101111;
            4'hA:    glyph = 7'b1110111;
            4'hB:    glyph = 7'b1111100;
            4'hC:    glyph = 7'b0111001;
            4'hD:    glyph = 7'b1011110;
            4'hE:    glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every nibble above it are zero; digit 0 always shows.
    always_comb begin
        case (idx_q)
            2'd1:    blank = (shadow_q[15:4] == 12'h000);
            2'd2:    blank = (shadow_q[15:8] == 8'h00);
            2'd3:    blank = (shadow_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_d  = (4'b0001 << idx_q) ^ {4{POL}};
        seg_d = (blank ? 7'b0000000 : glyph) ^ {7{POL}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            changed_q <= 1'b0;
            an_q      <= 4'b0001 ^ {4{POL}};
            seg_q     <= 7'b0111111 ^ {7{POL}};
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            changed_q <= changed_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an            = an_q;
    assign seg           = seg_q;
    assign dp            = POL;
    assign value_changed = changed_q;

endmodule
